// File: rtl/button_pulse_gen.sv
// Turns a raw bouncing push-button level into clean one-cycle increment pulses,
// with synchronisation, debounce, optional hold-to-repeat and a debounced level.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RELEASED    | debounced level low, waiting for the first high sample
// PRESS_CHK   | counting consecutive high samples before accepting a press
// PRESSED     | debounced level high, repeat timer running while held
// RELEASE_CHK | counting consecutive low samples; repeat timer frozen
module button_pulse_gen #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned RepeatDelay    = 16,
  parameter int unsigned RepeatPeriod   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o,
  output logic stable_o,
  output logic repeat_o
);

  localparam int unsigned MaxDebDly  = (DebounceCycles > RepeatDelay) ? DebounceCycles : RepeatDelay;
  localparam int unsigned MaxCycles  = (MaxDebDly > RepeatPeriod) ? MaxDebDly : RepeatPeriod;
  localparam int unsigned TimerWidth = $clog2(MaxCycles) + 1;

  localparam logic [TimerWidth-1:0] DebLoad   = TimerWidth'(DebounceCycles - 1);
  localparam logic [TimerWidth-1:0] DelayLoad = TimerWidth'(RepeatDelay);
  localparam logic [TimerWidth-1:0] PerLoad   = TimerWidth'(RepeatPeriod);
  localparam logic [TimerWidth-1:0] TcOne     = TimerWidth'(1);
  localparam bit                    RepeatEn  = (RepeatDelay != 0);
  localparam bit                    DebSingle = (DebounceCycles == 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  btn_s;

  state_e                state_q, state_d;
  logic [TimerWidth-1:0] deb_q, deb_d;
  logic [TimerWidth-1:0] rpt_q, rpt_d;
  logic                  pulse_q, pulse_d;
  logic                  repeat_q, repeat_d;
  logic                  stable_q, stable_d;
  logic                  do_press;
  logic                  rpt_adv;

  assign btn_s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], btn_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= RELEASED;
      deb_q    <= '0;
      rpt_q    <= '0;
      pulse_q  <= 1'b0;
      repeat_q <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      deb_q    <= deb_d;
      rpt_q    <= rpt_d;
      pulse_q  <= pulse_d;
      repeat_q <= repeat_d;
      stable_q <= stable_d;
    end
  end

  // deb_q holds the number of agreeing samples still needed; the entry sample counts as one
  always_comb begin
    state_d  = state_q;
    deb_d    = deb_q;
    rpt_d    = rpt_q;
    pulse_d  = 1'b0;
    repeat_d = 1'b0;
    stable_d = stable_q;
    do_press = 1'b0;
    rpt_adv  = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (btn_s) begin
          if (DebSingle) begin
            do_press = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            deb_d   = DebLoad;
          end
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = RELEASED;
        end else if (deb_q == TcOne) begin
          do_press = 1'b1;
        end else begin
          deb_d = deb_q - TcOne;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          if (DebSingle) begin
            state_d  = RELEASED;
            stable_d = 1'b0;
          end else begin
            state_d = RELEASE_CHK;
            deb_d   = DebLoad;
          end
        end else begin
          rpt_adv = 1'b1;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          // a short release glitch only pauses the repeat cadence
          state_d = PRESSED;
          rpt_adv = 1'b1;
        end else if (deb_q == TcOne) begin
          state_d  = RELEASED;
          stable_d = 1'b0;
        end else begin
          deb_d = deb_q - TcOne;
        end
      end
      default: state_d = RELEASED;
    endcase

    if (do_press) begin
      state_d  = PRESSED;
      pulse_d  = 1'b1;
      stable_d = 1'b1;
      rpt_d    = DelayLoad;
    end

    if (rpt_adv && RepeatEn) begin
      if (rpt_q == TcOne) begin
        pulse_d  = 1'b1;
        repeat_d = 1'b1;
        rpt_d    = PerLoad;
      end else begin
        rpt_d = rpt_q - TcOne;
      end
    end
  end

  assign pulse_o  = pulse_q;
  assign repeat_o = repeat_q;
  assign stable_o = stable_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios plus random button activity,
// checked against a run-length/hold-count reference model every cycle.
module tb_button_pulse_gen;

  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int DELAY  = 16;
  localparam int PERIOD = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic btn_i = 1'b0;
  logic btn_b = 1'b0;
  logic pulse_o, stable_o, repeat_o;
  logic pulse_b, stable_b, repeat_b;

  int n_asserts = 0;
  int n_fail = 0;
  int cyc = 0;

  int plog[$];
  bit rlog[$];
  int exp_c[$];
  bit exp_r[$];

  bit hist[$];
  bit s_m, prev_m, run_val;
  int run_len, held;
  bit m_pulse = 1'b0, m_repeat = 1'b0, m_stable = 1'b0;

  logic [3:0] cnt_b;

  int base, rel, r;

  button_pulse_gen #(
    .SyncStages(SYNC), .DebounceCycles(DEB), .RepeatDelay(DELAY), .RepeatPeriod(PERIOD)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i),
    .pulse_o(pulse_o), .stable_o(stable_o), .repeat_o(repeat_o)
  );

  button_pulse_gen #(
    .SyncStages(SYNC), .DebounceCycles(DEB), .RepeatDelay(0), .RepeatPeriod(PERIOD)
  ) u_chain (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_b),
    .pulse_o(pulse_b), .stable_o(stable_b), .repeat_o(repeat_b)
  );

  always #5 clk_i = ~clk_i;

  // downstream event counter, Limit=16
  always @(posedge clk_i) begin
    if (!rst_ni) cnt_b <= 4'd0;
    else if (pulse_b) cnt_b <= cnt_b + 4'd1;
  end

  // Reference: debounced level flips once the last DEB synchronised samples all
  // disagree with it; repeats fire at held counts DELAY, DELAY+PERIOD, ...
  always @(posedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      run_val = 1'b0; run_len = 0; held = 0;
      m_pulse = 1'b0; m_repeat = 1'b0; m_stable = 1'b0;
    end else begin
      hist.push_back(btn_i);
      s_m = hist[0];
      void'(hist.pop_front());
      prev_m = m_stable;
      m_pulse = 1'b0; m_repeat = 1'b0;
      if (s_m == run_val) run_len++;
      else begin run_val = s_m; run_len = 1; end
      if (prev_m && s_m) begin
        held++;
        if (DELAY != 0 && held >= DELAY && ((held - DELAY) % PERIOD) == 0) begin
          m_pulse = 1'b1; m_repeat = 1'b1;
        end
      end
      if (run_val != prev_m && run_len >= DEB) begin
        m_stable = run_val;
        if (run_val) begin m_pulse = 1'b1; held = 0; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    chk("model_pulse", pulse_o, m_pulse);
    chk("model_repeat", repeat_o, m_repeat);
    chk("model_stable", stable_o, m_stable);
    if (pulse_o === 1'b1) begin
      plog.push_back(cyc);
      rlog.push_back(repeat_o);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_logs();
    plog.delete(); rlog.delete(); exp_c.delete(); exp_r.delete();
  endtask

  task automatic expect_pulse(input int c, input bit rp);
    exp_c.push_back(c);
    exp_r.push_back(rp);
  endtask

  task automatic check_log(input string tag);
    chk($sformatf("%s_count", tag), plog.size(), exp_c.size());
    for (int i = 0; i < exp_c.size(); i++) begin
      if (i < plog.size()) begin
        chk($sformatf("%s_cyc%0d", tag, i), plog[i], exp_c[i]);
        chk($sformatf("%s_rep%0d", tag, i), rlog[i], exp_r[i]);
      end
    end
  endtask

  initial begin
    bit pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset state
    wait_cyc(3);
    chk("rst_pulse", pulse_o, 0);
    chk("rst_stable", stable_o, 0);
    chk("rst_repeat", repeat_o, 0);
    rst_ni = 1'b1;
    wait_cyc(5);

    // clean press: 10 high, then 10 low
    clear_logs();
    base = cyc;
    btn_i = 1'b1;
    wait_cyc(10);
    btn_i = 1'b0;
    rel = cyc;
    wait_cyc(5);
    chk("clean_stable_hold", stable_o, 1);
    wait_cyc(1);
    chk("clean_stable_fall", stable_o, 0);
    wait_cyc(6);
    expect_pulse(base + 6, 1'b0);
    check_log("clean");

    // bounce rejection
    clear_logs();
    foreach (pat[i]) begin
      btn_i = pat[i];
      wait_cyc(1);
    end
    btn_i = 1'b0;
    wait_cyc(10);
    check_log("bounce");
    chk("bounce_stable", stable_o, 0);

    // auto-repeat
    clear_logs();
    base = cyc;
    btn_i = 1'b1;
    wait_cyc(38);
    btn_i = 1'b0;
    wait_cyc(12);
    expect_pulse(base + 6, 1'b0);
    for (int k = 0; k < 5; k++) expect_pulse(base + 6 + DELAY + k * PERIOD, 1'b1);
    check_log("repeat");

    // release glitch while held delays the next repeat by its length
    clear_logs();
    base = cyc;
    btn_i = 1'b1;
    wait_cyc(10);
    btn_i = 1'b0;
    wait_cyc(2);
    btn_i = 1'b1;
    wait_cyc(4);
    chk("glitch_stable", stable_o, 1);
    wait_cyc(9);
    btn_i = 1'b0;
    wait_cyc(12);
    expect_pulse(base + 6, 1'b0);
    expect_pulse(base + 6 + DELAY + 2, 1'b1);
    check_log("glitch");

    // reset while pressed, button still held
    clear_logs();
    btn_i = 1'b1;
    wait_cyc(10);
    chk("pre_rst_stable", stable_o, 1);
    rst_ni = 1'b0;
    wait_cyc(1);
    chk("midrst_pulse", pulse_o, 0);
    chk("midrst_stable", stable_o, 0);
    chk("midrst_repeat", repeat_o, 0);
    rst_ni = 1'b1;
    clear_logs();
    r = cyc;
    wait_cyc(10);
    btn_i = 1'b0;
    wait_cyc(12);
    expect_pulse(r + 6, 1'b0);
    check_log("after_rst");

    // repeat disabled, feeding the counter
    chk("chain_cnt_before", cnt_b, 0);
    btn_b = 1'b1;
    wait_cyc(50);
    chk("chain_stable_hi", stable_b, 1);
    btn_b = 1'b0;
    wait_cyc(10);
    chk("chain_cnt_after", cnt_b, 1);
    chk("chain_stable_lo", stable_b, 0);

    // random activity, checked by the model
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst_ni = 1'b0;
        wait_cyc(1);
        rst_ni = 1'b1;
      end
      btn_i = ($urandom_range(0, 1) == 1);
      wait_cyc($urandom_range(1, 24));
    end
    btn_i = 1'b0;
    wait_cyc(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
